// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Sequential instruction fetcher with a small prefetch buffer. It keeps at
//   most one instruction-memory request in flight, pushes each returned word
//   together with its fetch address into a DEPTH-entry FIFO, and presents the
//   FIFO head to the decode stage. A redirect flushes the buffer and restarts
//   fetching at the new (word-aligned) address. A response that belongs to a
//   request made before a redirect is dropped.
//
// Parameters
//   ADDR_W   instruction address width (>= 3)
//   DATA_W   instruction word width
//   DEPTH    prefetch buffer entries (power of 2, >= 2)
//   RESET_PC fetch address after reset (word aligned)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   imem_req     one-cycle request pulse to instruction memory
//   imem_addr    request address, always word aligned
//   imem_ack     one-cycle response strobe
//   imem_rdata   response word, valid with imem_ack
//   redirect     redirect strobe (branch / jump / exception)
//   redirect_pc  new fetch address; the two low bits are ignored
//   out_valid    buffer head holds an instruction
//   out_ready    decode accepts the head this cycle
//   out_instr    head instruction word
//   out_pc       address the head instruction was fetched from
//   out_count    buffer occupancy

module instr_fetch_unit #(
  parameter int unsigned        ADDR_W   = 9,
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         imem_req,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic                         imem_ack,
  input  logic [DATA_W-1:0]            imem_rdata,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_instr,
  output logic [ADDR_W-1:0]            out_pc,
  output logic [$clog2(DEPTH+1)-1:0]   out_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] PC_RESET = {RESET_PC[ADDR_W-1:2], 2'b00};

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e               state_q,  state_d;
  logic [ADDR_W-1:0]    pc_q,     pc_d;
  logic [ADDR_W-1:0]    npc_q,    npc_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q,  count_d;

  logic [DATA_W-1:0]    instr_mem_q [DEPTH];
  logic [ADDR_W-1:0]    pc_mem_q    [DEPTH];

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  logic                 fetch_req;
  logic                 push;
  logic                 pop;
  logic                 has_space;
  logic [ADDR_W-1:0]    redirect_base;
  logic [1:0]           unused_redirect_lsbs;

  assign unused_redirect_lsbs = redirect_pc[1:0];
  assign redirect_base        = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign has_space            = (count_q < CNT_W'(DEPTH));

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    npc_d     = npc_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    fetch_req = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        // Any imem_ack seen here answers an abandoned request and is ignored.
        if (!redirect && has_space) begin
          fetch_req = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          // A response arriving with the redirect closes the old request now;
          // otherwise it is still in flight and must be dropped later.
          state_d = imem_ack ? S_FETCH : S_DISCARD;
        end else if (imem_ack) begin
          push    = 1'b1;
          pc_d    = npc_q;
          npc_d   = npc_q + PC_STEP;
          state_d = S_FETCH;
        end
      end
      S_DISCARD: begin
        if (imem_ack) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (redirect) begin
      // Flush wins over any push or pop in the same cycle.
      pc_d     = redirect_base;
      npc_d    = redirect_base + PC_STEP;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      pop = (count_q != '0) && out_ready;
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      pc_q     <= PC_RESET;
      npc_q    <= PC_RESET + PC_STEP;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      npc_q    <= npc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        instr_mem_q[wr_ptr_q] <= imem_rdata;
        pc_mem_q[wr_ptr_q]    <= pc_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The request is issued in the FETCH cycle itself so a new fetch follows an
  // ack with no bubble; it is held low while reset is asserted.
  assign imem_req  = fetch_req && reset;
  assign imem_addr = {pc_q[ADDR_W-1:2], 2'b00};

  assign out_valid = (count_q != '0);
  assign out_count = count_q;
  assign out_instr = instr_mem_q[rd_ptr_q];
  assign out_pc    = pc_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// transaction-level model (outstanding-request flag plus instruction queue).

module tb_instr_fetch_unit;

  localparam int unsigned AW  = 9;
  localparam int unsigned DW  = 32;
  localparam int unsigned DEP = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic [2:0]    out_count;

  instr_fetch_unit #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .DEPTH    (DEP),
    .RESET_PC (9'h000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_count   (out_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lat_lo   = 1;
  int lat_hi   = 1;
  bit rand_data = 1'b0;

  // memory responder: in-order pending responses
  int            pend_due  [$];
  logic [DW-1:0] pend_data [$];

  // reference model
  logic [AW-1:0] m_pc;
  bit            m_busy;
  bit            m_want;
  logic [DW-1:0] q_instr [$];
  logic [AW-1:0] q_pc    [$];

  // outputs sampled mid-cycle
  logic          s_req;
  logic [AW-1:0] s_addr;
  logic          s_valid;
  logic [DW-1:0] s_instr;
  logic [AW-1:0] s_pc;
  logic [2:0]    s_count;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = 9'h000;
    m_busy = 1'b0;
    m_want = 1'b0;
    q_instr.delete();
    q_pc.delete();
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic step(input logic rd, input logic [AW-1:0] rpc, input logic rdy);
    logic          ack;
    logic [DW-1:0] rdata;
    bit            exp_req;
    int            n;
    redirect    = rd;
    redirect_pc = rpc;
    out_ready   = rdy;
    ack         = 1'b0;
    rdata       = $urandom;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      ack   = 1'b1;
      rdata = pend_data[0];
      void'(pend_due.pop_front());
      void'(pend_data.pop_front());
    end
    imem_ack   = ack;
    imem_rdata = rdata;
    #4;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = out_valid;
    s_instr = out_instr;
    s_pc    = out_pc;
    s_count = out_count;
    if (!reset) begin
      chk("rst_imem_req",  32'(s_req),   32'd0);
      chk("rst_out_count", 32'(s_count), 32'd0);
      chk("rst_out_valid", 32'(s_valid), 32'd0);
      chk("rst_out_instr", s_instr,      32'd0);
      chk("rst_out_pc",    32'(s_pc),    32'd0);
    end else begin
      n       = q_pc.size();
      exp_req = !m_busy && !rd && (n < DEP);
      chk("imem_req", 32'(s_req), 32'(exp_req));
      if (exp_req) chk("imem_addr", 32'(s_addr), 32'(m_pc));
      chk("out_count", 32'(s_count), 32'(n));
      chk("out_valid", 32'(s_valid), 32'(n != 0));
      if (n > 0) begin
        chk("out_pc",    32'(s_pc), 32'(q_pc[0]));
        chk("out_instr", s_instr,   q_instr[0]);
      end
      if (rd) begin
        q_pc.delete();
        q_instr.delete();
        m_pc = {rpc[AW-1:2], 2'b00};
        if (m_busy) begin
          if (ack) m_busy = 1'b0;
          else     m_want = 1'b0;
        end
      end else begin
        if (n > 0 && rdy) begin
          void'(q_pc.pop_front());
          void'(q_instr.pop_front());
        end
        if (!m_busy) begin
          if (exp_req) begin
            m_busy = 1'b1;
            m_want = 1'b1;
          end
        end else if (ack) begin
          m_busy = 1'b0;
          if (m_want) begin
            q_pc.push_back(m_pc);
            q_instr.push_back(rdata);
            m_pc = m_pc + 9'd4;
          end
        end
      end
    end
    if (s_req) begin
      pend_due.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
      pend_data.push_back(rand_data ? 32'($urandom) : (32'hD000_0000 | 32'(s_addr)));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int          nreq;
    int          nv;
    int          first_v;
    logic [31:0] ra [4];
    logic [31:0] vp [4];
    logic [31:0] vi [4];

    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    model_reset();
    @(posedge clk);
    #1;
    step(1'b0, 9'h000, 1'b0);
    step(1'b0, 9'h000, 1'b0);
    reset = 1'b1;

    // sequential fetch, latency 1, decode always ready
    lat_lo = 1; lat_hi = 1;
    nreq = 0; nv = 0; first_v = -1;
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 9'h000, 1'b1);
      if (s_req) begin
        if (nreq < 4) ra[nreq] = 32'(s_addr);
        nreq++;
      end
      if (s_valid) begin
        if (nv < 4) begin
          vp[nv] = 32'(s_pc);
          vi[nv] = s_instr;
        end
        if (first_v < 0) first_v = i;
        nv++;
      end
    end
    chk("seq_nreq", 32'(nreq), 32'd5);
    chk("seq_nvalid", 32'(nv), 32'd4);
    chk("seq_first_visible", 32'(first_v), 32'd2);
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr",      ra[i], 32'(4 * i));
      chk("seq_out_pc",    vp[i], 32'(4 * i));
      chk("seq_out_instr", vi[i], 32'hD000_0000 | 32'(4 * i));
    end

    // redirect together with ack: data dropped, refetch at target next cycle
    step(1'b1, 9'h100, 1'b0);
    chk("redir_ack_req", 32'(s_req), 32'd0);
    step(1'b0, 9'h000, 1'b0);
    chk("redir_ack_next_req",   32'(s_req),   32'd1);
    chk("redir_ack_next_addr",  32'(s_addr),  32'h100);
    chk("redir_ack_next_count", 32'(s_count), 32'd0);

    // backpressure: buffer fills with exactly DEPTH requests
    nreq = 1;
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 9'h000, 1'b0);
      if (s_req) nreq++;
    end
    chk("bp_nreq",  32'(nreq),    32'd4);
    chk("bp_count", 32'(s_count), 32'd4);
    chk("bp_req",   32'(s_req),   32'd0);
    step(1'b0, 9'h000, 1'b1);
    chk("bp_head_valid", 32'(s_valid), 32'd1);
    chk("bp_head_pc",    32'(s_pc),    32'h100);
    chk("bp_head_instr", s_instr,      32'hD000_0100);
    step(1'b0, 9'h000, 1'b0);
    chk("bp_refill_count", 32'(s_count), 32'd3);
    chk("bp_refill_req",   32'(s_req),   32'd1);
    chk("bp_refill_addr",  32'(s_addr),  32'h110);
    step(1'b0, 9'h000, 1'b0);
    step(1'b0, 9'h000, 1'b0);
    chk("bp_full_count", 32'(s_count), 32'd4);
    chk("bp_full_req",   32'(s_req),   32'd0);

    // redirect while waiting, ack two cycles later is dropped
    step(1'b0, 9'h000, 1'b1);
    lat_lo = 3; lat_hi = 3;
    step(1'b0, 9'h000, 1'b0);
    chk("rw_req",  32'(s_req),  32'd1);
    chk("rw_addr", 32'(s_addr), 32'h114);
    step(1'b1, 9'h040, 1'b0);
    step(1'b0, 9'h000, 1'b0);
    chk("rw_flush_count", 32'(s_count), 32'd0);
    chk("rw_discard_req", 32'(s_req),   32'd0);
    step(1'b0, 9'h000, 1'b0);
    chk("rw_late_ack_req", 32'(s_req), 32'd0);
    lat_lo = 1; lat_hi = 1;
    step(1'b0, 9'h000, 1'b0);
    chk("rw_target_req",  32'(s_req),  32'd1);
    chk("rw_target_addr", 32'(s_addr), 32'h040);
    step(1'b0, 9'h000, 1'b0);
    step(1'b0, 9'h000, 1'b0);
    chk("rw_first_valid", 32'(s_valid), 32'd1);
    chk("rw_first_pc",    32'(s_pc),    32'h040);
    chk("rw_first_instr", s_instr,      32'hD000_0040);

    // address wrap and redirect alignment
    step(1'b1, 9'h1FC, 1'b1);
    step(1'b0, 9'h000, 1'b1);
    chk("wrap_req0",  32'(s_req),  32'd1);
    chk("wrap_addr0", 32'(s_addr), 32'h1FC);
    step(1'b0, 9'h000, 1'b1);
    step(1'b0, 9'h000, 1'b1);
    chk("wrap_req1",  32'(s_req),  32'd1);
    chk("wrap_addr1", 32'(s_addr), 32'h000);
    chk("wrap_pc0",   32'(s_pc),   32'h1FC);
    step(1'b0, 9'h000, 1'b1);
    step(1'b0, 9'h000, 1'b1);
    step(1'b1, 9'h0A3, 1'b1);
    lat_lo = 2; lat_hi = 2;
    step(1'b0, 9'h000, 1'b1);
    chk("align_req",  32'(s_req),  32'd1);
    chk("align_addr", 32'(s_addr), 32'h0A0);

    // reset during WAIT, stale ack lands after release
    reset = 1'b0;
    model_reset();
    step(1'b0, 9'h000, 1'b1);
    reset = 1'b1;
    lat_lo = 1; lat_hi = 1;
    step(1'b0, 9'h000, 1'b1);
    chk("rst_wait_req",   32'(s_req),   32'd1);
    chk("rst_wait_addr",  32'(s_addr),  32'h000);
    chk("rst_wait_count", 32'(s_count), 32'd0);
    step(1'b0, 9'h000, 1'b1);
    chk("rst_stale_count", 32'(s_count), 32'd0);
    chk("rst_stale_valid", 32'(s_valid), 32'd0);
    step(1'b0, 9'h000, 1'b0);
    chk("rst_new_valid", 32'(s_valid), 32'd1);
    chk("rst_new_pc",    32'(s_pc),    32'h000);
    chk("rst_new_instr", s_instr,      32'hD000_0000);

    // randomized traffic
    rand_data = 1'b1;
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199, 0) == 0) begin
        reset = 1'b0;
        model_reset();
        step(1'($urandom), 9'($urandom), 1'($urandom));
        if ($urandom_range(1, 0) == 1) step(1'($urandom), 9'($urandom), 1'($urandom));
        reset = 1'b1;
      end
      step(($urandom_range(15, 0) == 0), 9'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 9, instruction address width in bits (>= 3).
REQ-002 Parameter DATA_W, default 32, instruction word width.
REQ-003 Parameter DEPTH, default 4, prefetch buffer entries (power of 2, >= 2).
REQ-004 Parameter RESET_PC, default 0, fetch address after reset (word aligned).
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 imem_req  out  1  one-cycle request pulse to instruction memory.
REQ-008 imem_addr  out  ADDR_W  request address; valid when imem_req=1.
REQ-009 imem_ack  in  1  response strobe, one cycle, >= 1 cycle after imem_req.
REQ-010 imem_rdata  in  DATA_W  response word; valid when imem_ack=1.
REQ-011 redirect  in  1  branch/jump/exception redirect strobe.
REQ-012 redirect_pc  in  ADDR_W  new fetch address; bits [1:0] ignored.
REQ-013 out_valid  out  1  buffer head holds an instruction.
REQ-014 out_ready  in  1  decode stage accepts head this cycle.
REQ-015 out_instr  out  DATA_W  head instruction word.
REQ-016 out_pc  out  ADDR_W  address from which out_instr was fetched.
REQ-017 out_count  out  clog2(DEPTH+1)  buffer occupancy.

Function
REQ-018 Internal pc and npc registers; npc SHALL always equal pc+4 modulo 2^ADDR_W.
REQ-019 FSM states FETCH, WAIT, DISCARD; at most one memory request outstanding.
REQ-020 FETCH: if out_count<DEPTH and redirect=0, assert imem_req with imem_addr=pc and go to WAIT; otherwise stay, imem_req=0.
REQ-021 WAIT: on imem_ack with redirect=0, push {imem_rdata, pc} at buffer tail, pc<=npc, npc<=npc+4, go to FETCH.
REQ-022 WAIT: on redirect (with or without imem_ack), flush buffer, pc<={redirect_pc[ADDR_W-1:2],2'b00}, go to DISCARD if no imem_ack that cycle, otherwise to FETCH, discarding the data.
REQ-023 DISCARD: imem_ack dropped, go to FETCH; a further redirect updates pc, state unchanged unless imem_ack that cycle.
REQ-024 FETCH: redirect flushes buffer, loads pc, suppresses imem_req that cycle; imem_ack in FETCH is stale and ignored.
REQ-025 Pop occurs when out_valid=1 and out_ready=1; simultaneous push and pop leaves out_count unchanged.
REQ-026 Redirect flush takes priority over push and pop; out_count is 0 the cycle after any redirect.
REQ-027 out_valid=(out_count!=0); out_instr/out_pc driven from registered head entry, stable while out_valid=1 and out_ready=0.
REQ-028 Latency: imem_ack at edge t makes the word visible at out_instr with out_valid=1 after edge t; next imem_req asserted in the following cycle if space.
REQ-029 Buffer pointers wrap modulo DEPTH; pc wraps modulo 2^ADDR_W without error.
REQ-030 imem_addr[1:0] SHALL always be 0.

Reset
REQ-031 On reset low: pc=RESET_PC, npc=RESET_PC+4, state FETCH, buffer empty, out_count=0, out_valid=0, imem_req=0, out_instr=0, out_pc=0.
REQ-032 Reset asserted mid-WAIT abandons the request; the late imem_ack arrives in FETCH and is ignored per REQ-024.
REQ-033 First imem_req with imem_addr=RESET_PC in the first cycle after reset deasserts.

Verification
REQ-034 Sequential fetch, memory latency 1, out_ready=1: addresses 0,4,8,12 requested; out_pc 0,4,8,12 with matching words, each visible one cycle after its ack.
REQ-035 Backpressure, out_ready=0, DEPTH=4: exactly 4 requests, out_count=4, imem_req stays 0; one pop -> one new request next cycle.
REQ-036 Redirect to 0x40 while WAIT with ack 2 cycles later: buffer flushed, ack dropped, next imem_addr=0x40, out_pc=0x40 first.
REQ-037 Redirect and imem_ack same cycle: data discarded, next cycle imem_req with imem_addr=redirect_pc.
REQ-038 Wrap: RESET_PC=0x1FC, ADDR_W=9: requests 0x1FC then 0x000; redirect_pc=0x0A3 -> imem_addr=0x0A0.
REQ-039 Reset asserted in WAIT, ack delivered after release: output stays empty, first request at RESET_PC, stale ack ignored.
